// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator: divides clk_i by a loadable int+frac divisor to make an
// oversample tick, and derives mid-bit / end-of-bit ticks from the oversample phase.
module baud_tick_gen #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned FRAC_W      = 4,
    parameter int unsigned OVS         = 16,
    parameter int unsigned DEFAULT_DIV = 27
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [CNT_W-1:0]        div_int_i,
    input  logic [FRAC_W-1:0]       div_frac_i,
    input  logic                    div_load_i,
    input  logic                    resync_i,
    output logic                    os_tick_o,
    output logic                    mid_tick_o,
    output logic                    bit_tick_o,
    output logic [$clog2(OVS)-1:0]  os_phase_o,
    output logic                    div_err_o
);

    localparam int unsigned PhW = $clog2(OVS);
    localparam logic [PhW-1:0] MidPh = PhW'(OVS / 2 - 1);
    localparam logic [PhW-1:0] BitPh = PhW'(OVS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [PhW-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]  div_int_act_q, div_int_act_d;
    logic [FRAC_W-1:0] div_frac_act_q, div_frac_act_d;
    logic              pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              os_tick_q, os_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              div_err_q, div_err_d;

    logic              load_ok;
    logic              period_end;
    logic [CNT_W:0]    limit;
    logic [FRAC_W:0]   frac_sum;

    // One bit wider so that a full-scale divisor plus carry cannot wrap.
    assign limit = {1'b0, div_int_act_q} + {{CNT_W{1'b0}}, carry_q} - (CNT_W + 1)'(1);
    assign period_end = en_i && ({1'b0, cnt_q} == limit);
    assign frac_sum = {1'b0, acc_q} + {1'b0, div_frac_act_q};
    assign load_ok = div_load_i && (div_int_i >= CNT_W'(2));

    always_comb begin
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        carry_d        = carry_q;
        phase_d        = phase_q;
        div_int_act_d  = div_int_act_q;
        div_frac_act_d = div_frac_act_q;
        pend_vld_d     = pend_vld_q;
        pend_int_d     = pend_int_q;
        pend_frac_d    = pend_frac_q;
        os_tick_d      = 1'b0;
        mid_tick_d     = 1'b0;
        bit_tick_d     = 1'b0;
        div_err_d      = div_load_i && !load_ok;

        if (load_ok) begin
            pend_vld_d  = 1'b1;
            pend_int_d  = div_int_i;
            pend_frac_d = div_frac_i;
        end

        if (resync_i) begin
            cnt_d   = '0;
            acc_d   = '0;
            carry_d = 1'b0;
            phase_d = '0;
            // Includes a load captured in this same cycle.
            if (pend_vld_d) begin
                div_int_act_d  = pend_int_d;
                div_frac_act_d = pend_frac_d;
                pend_vld_d     = 1'b0;
            end
        end else begin
            // The phase advances the cycle after each tick, so os_phase_o shows the index of
            // the oversample period that the tick closes.
            if (os_tick_q) begin
                phase_d = phase_q + PhW'(1);
            end
            if (period_end) begin
                cnt_d      = '0;
                os_tick_d  = 1'b1;
                mid_tick_d = (phase_q == MidPh);
                bit_tick_d = (phase_q == BitPh);
                if (pend_vld_q) begin
                    div_int_act_d  = pend_int_q;
                    div_frac_act_d = pend_frac_q;
                    acc_d          = '0;
                    carry_d        = 1'b0;
                    pend_vld_d     = load_ok;
                end else begin
                    {carry_d, acc_d} = frac_sum;
                end
            end else if (en_i) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q          <= '0;
            acc_q          <= '0;
            carry_q        <= 1'b0;
            phase_q        <= '0;
            div_int_act_q  <= CNT_W'(DEFAULT_DIV);
            div_frac_act_q <= '0;
            pend_vld_q     <= 1'b0;
            pend_int_q     <= '0;
            pend_frac_q    <= '0;
            os_tick_q      <= 1'b0;
            mid_tick_q     <= 1'b0;
            bit_tick_q     <= 1'b0;
            div_err_q      <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            carry_q        <= carry_d;
            phase_q        <= phase_d;
            div_int_act_q  <= div_int_act_d;
            div_frac_act_q <= div_frac_act_d;
            pend_vld_q     <= pend_vld_d;
            pend_int_q     <= pend_int_d;
            pend_frac_q    <= pend_frac_d;
            os_tick_q      <= os_tick_d;
            mid_tick_q     <= mid_tick_d;
            bit_tick_q     <= bit_tick_d;
            div_err_q      <= div_err_d;
        end
    end

    assign os_tick_o  = os_tick_q;
    assign mid_tick_o = mid_tick_q;
    assign bit_tick_o = bit_tick_q;
    assign os_phase_o = phase_q;
    assign div_err_o  = div_err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: a cycle-counting reference model predicts tick and error
// events; a monitor pops and compares them as the DUT produces outputs.
module tb_baud_tick_gen;

    localparam int CW  = 8;
    localparam int FW  = 4;
    localparam int OVS = 16;
    localparam int DEF = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0, ld = 1'b0, rs = 1'b0;
    logic [CW-1:0] di = '0;
    logic [FW-1:0] df = '0;
    logic          os_tick, mid_tick, bit_tick, div_err;
    logic [3:0]    os_phase;

    baud_tick_gen #(
        .CNT_W       (CW),
        .FRAC_W      (FW),
        .OVS         (OVS),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .div_int_i  (di),
        .div_frac_i (df),
        .div_load_i (ld),
        .resync_i   (rs),
        .os_tick_o  (os_tick),
        .mid_tick_o (mid_tick),
        .bit_tick_o (bit_tick),
        .os_phase_o (os_phase),
        .div_err_o  (div_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stamp;
        int mid;
        int bt;
        int ph;
    } tick_t;

    tick_t tq[$];
    int    eq[$];
    int    total = 0;
    int    bad = 0;
    int    edge_n = 0;
    int    tick_cnt = 0;

    // Reference model: divisor, fraction accumulator, pending load, cycles since last tick.
    int m_div, m_frac, m_acc, m_carry, m_pv, m_pdiv, m_pfrac, m_el, m_ticks;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endfunction

    function automatic void model_reset();
        m_div = DEF; m_frac = 0; m_acc = 0; m_carry = 0;
        m_pv = 0; m_pdiv = 0; m_pfrac = 0; m_el = 0; m_ticks = 0;
        tq.delete();
        eq.delete();
    endfunction

    // Predicts the effect of the coming rising edge given the inputs now driven.
    function automatic void model_step();
        int    e = edge_n + 1;
        bit    ok = ld && (int'(di) >= 2);
        int    s;
        tick_t t;
        if (ld && !ok) eq.push_back(e);
        if (rs) begin
            if (ok) begin
                m_div = int'(di); m_frac = int'(df); m_pv = 0;
            end else if (m_pv != 0) begin
                m_div = m_pdiv; m_frac = m_pfrac; m_pv = 0;
            end
            m_el = 0; m_acc = 0; m_carry = 0; m_ticks = 0;
            return;
        end
        if (en) begin
            m_el++;
            if (m_el == m_div + m_carry) begin
                t.stamp = e;
                t.ph    = m_ticks % OVS;
                t.mid   = (t.ph == OVS / 2 - 1) ? 1 : 0;
                t.bt    = (t.ph == OVS - 1) ? 1 : 0;
                tq.push_back(t);
                m_ticks++;
                m_el = 0;
                if (m_pv != 0) begin
                    m_div = m_pdiv; m_frac = m_pfrac; m_pv = 0; m_acc = 0; m_carry = 0;
                end else begin
                    s = m_acc + m_frac;
                    m_carry = s / (2 ** FW);
                    m_acc = s % (2 ** FW);
                end
            end
        end
        if (ok) begin
            m_pv = 1; m_pdiv = int'(di); m_pfrac = int'(df);
        end
    endfunction

    task automatic step(input bit e, input bit l, input bit r, input int d, input int f);
        @(negedge clk);
        en = e; ld = l; rs = r; di = CW'(d); df = FW'(f);
        model_step();
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_os_tick"}, 32'(os_tick), 0);
        chk({tag, "_mid_tick"}, 32'(mid_tick), 0);
        chk({tag, "_bit_tick"}, 32'(bit_tick), 0);
        chk({tag, "_os_phase"}, 32'(os_phase), 0);
        chk({tag, "_div_err"}, 32'(div_err), 0);
    endtask

    task automatic async_reset(string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_zero(tag);
        en = 1'b0; ld = 1'b0; rs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    tick_t mt;
    int    me;

    always @(posedge clk) begin
        edge_n++;
        #1;
        if (!rst) begin
            while (tq.size() > 0 && tq[0].stamp < edge_n) begin
                mt = tq.pop_front();
                chk("tick_missed", 0, 32'(mt.stamp));
            end
            while (eq.size() > 0 && eq[0] < edge_n) begin
                me = eq.pop_front();
                chk("err_missed", 0, 32'(me));
            end
            if (os_tick) begin
                tick_cnt++;
                if (tq.size() > 0 && tq[0].stamp == edge_n) begin
                    mt = tq.pop_front();
                    chk("mid_tick", 32'(mid_tick), 32'(mt.mid));
                    chk("bit_tick", 32'(bit_tick), 32'(mt.bt));
                    chk("os_phase", 32'(os_phase), 32'(mt.ph));
                end else begin
                    chk("tick_spurious", 1, 0);
                end
            end else if (mid_tick || bit_tick) begin
                chk("stray_mid_bit", 1, 0);
            end
            if (div_err) begin
                if (eq.size() > 0 && eq[0] == edge_n) begin
                    me = eq.pop_front();
                    chk("div_err", 32'(div_err), 1);
                end else begin
                    chk("err_spurious", 1, 0);
                end
            end
        end
    end

    int snap;
    bit found;

    initial begin
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Default divisor, then integer divisor 4 with no fraction.
        repeat (40) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 4, 0);
        repeat (160) step(1, 0, 0, 0, 0);

        // 4 + 8/16 from resync: 32 ticks take exactly 143 cycles.
        step(1, 1, 1, 4, 8);
        snap = tick_cnt;
        repeat (144) step(1, 0, 0, 0, 0);
        chk("frac_tick_count", 32'(tick_cnt - snap), 32);

        // Load mid-period: current period of 6 completes, then 10; invalid load flags an error.
        step(1, 1, 1, 6, 0);
        repeat (2) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 10, 0);
        repeat (40) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        repeat (30) step(1, 0, 0, 0, 0);

        // Freeze mid-period, then resume.
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0, 0);
        repeat (40) step(1, 0, 0, 0, 0);

        // Randomised enable / load / resync traffic.
        for (int i = 0; i < 4000; i++) begin
            int d;
            d = ($urandom_range(0, 63) == 0) ? 255 : int'($urandom_range(0, 12));
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 99) == 0), d, int'($urandom_range(0, 15)));
        end

        // Asynchronous reset while os_tick is high.
        step(1, 1, 1, 6, 3);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1, 0, 0, 0, 0);
            if (os_tick) found = 1'b1;
        end
        chk("wait_tick_for_reset", 32'(found), 1);
        async_reset("rst_on_tick");
        repeat (30) step(1, 0, 0, 0, 0);

        // Pending load discarded by reset: periods return to the default divisor.
        step(1, 1, 0, 11, 0);
        repeat (2) step(1, 0, 0, 0, 0);
        async_reset("rst_pending");
        snap = tick_cnt;
        repeat (60) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("default_after_reset", 32'(tick_cnt - snap), 60 / DEF);

        repeat (3) step(0, 0, 0, 0, 0);
        #2;
        chk("tick_queue_drained", 32'(tq.size()), 0);
        chk("err_queue_drained", 32'(eq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
